// File: rtl/timer_wb_pkg.sv
// Shared register map, field positions and helpers for the Wishbone timer.
package timer_wb_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_LOAD  = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int unsigned CTRL_EN = 32'd0;
  localparam int unsigned CTRL_AR = 32'd1;
  localparam int unsigned CTRL_IE = 32'd2;

  localparam int unsigned STAT_IRQ       = 32'd0;
  localparam int unsigned STAT_PRESC_LSB = 32'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res[7:0]   = sel[0] ? new_v[7:0]   : old_v[7:0];
    res[15:8]  = sel[1] ? new_v[15:8]  : old_v[15:8];
    res[23:16] = sel[2] ? new_v[23:16] : old_v[23:16];
    res[31:24] = sel[3] ? new_v[31:24] : old_v[31:24];
    return res;
  endfunction

endpackage

// File: rtl/timer_wb_prescaler.sv
// Prescaler: divides the clock by (presc+1) while enabled, emitting a one-cycle tick
// whenever its counter sits at zero.
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_r;

  // Count down while enabled, reload at zero; park at the reload value when disabled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pcnt_r <= {PRESC_W{1'b0}};
    end else if (!en) begin
      pcnt_r <= presc;
    end else if (pcnt_r == {PRESC_W{1'b0}}) begin
      pcnt_r <= presc;
    end else begin
      pcnt_r <= pcnt_r - {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = en & (pcnt_r == {PRESC_W{1'b0}});

endmodule

// File: rtl/timer_wb.sv
// Wishbone classic responder exposing a 32-bit down-counting timer with prescaler,
// auto-reload and level interrupt in a 16-byte register window.
module timer_wb
  import timer_wb_pkg::*;
#(
  parameter logic [31:0] base_addr = 32'h00000410,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [31:0] adr_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        irq_o
);

  bus_state_e         state_r;
  logic [31:0]        dat_r;
  logic               en_r;
  logic               ar_r;
  logic               ie_r;
  logic               irq_r;
  logic [31:0]        load_r;
  logic [31:0]        count_r;
  logic [PRESC_W-1:0] presc_r;

  logic        addr_hit_s;
  logic        req_s;
  logic        wr_s;
  logic [1:0]  reg_sel_s;
  logic        wr_ctrl_s;
  logic        wr_load_s;
  logic        wr_count_s;
  logic        wr_stat_s;
  logic [2:0]  ctrl_new_s;
  logic [31:0] ctrl_rd_s;
  logic [31:0] stat_rd_s;
  logic [31:0] load_wr_s;
  logic [31:0] count_wr_s;
  logic [31:0] stat_wr_s;
  logic [31:0] rd_data_s;
  logic        tick_s;
  logic        tick_eff_s;
  logic        en_clear_wr_s;
  logic        expire_s;
  logic        unused_s;

  assign addr_hit_s = (adr_i[31:4] == base_addr[31:4]);
  assign req_s      = cyc_i & stb_i & addr_hit_s & (state_r == ST_IDLE);
  assign wr_s       = req_s & we_i;
  assign reg_sel_s  = adr_i[3:2];
  assign wr_ctrl_s  = wr_s & (reg_sel_s == REG_CTRL);
  assign wr_load_s  = wr_s & (reg_sel_s == REG_LOAD);
  assign wr_count_s = wr_s & (reg_sel_s == REG_COUNT);
  assign wr_stat_s  = wr_s & (reg_sel_s == REG_STAT);

  assign ctrl_rd_s  = {29'd0, ie_r, ar_r, en_r};
  assign stat_rd_s  = {16'(presc_r), 15'd0, irq_r};
  assign ctrl_new_s = sel_i[0] ? dat_i[2:0] : ctrl_rd_s[2:0];
  assign load_wr_s  = byte_merge(load_r, dat_i, sel_i);
  assign count_wr_s = byte_merge(count_r, dat_i, sel_i);
  assign stat_wr_s  = byte_merge(stat_rd_s, dat_i, sel_i);
  assign unused_s   = ^{adr_i[1:0], stat_wr_s[15:0]};

  // A bus write that drops EN swallows the tick of the same edge; a bus write to
  // COUNT/LOAD overrides the tick, so that edge is not an expiry either.
  assign en_clear_wr_s = wr_ctrl_s & ~ctrl_new_s[CTRL_EN];
  assign tick_eff_s    = tick_s & ~en_clear_wr_s;
  assign expire_s      = tick_eff_s & (count_r == 32'd1) & ~wr_load_s & ~wr_count_s;

  timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (en_r),
    .presc (presc_r),
    .tick  (tick_s)
  );

  // Read mux over the addressed register (pre-write values).
  always_comb begin
    rd_data_s = 32'd0;
    case (reg_sel_s)
      REG_CTRL:  rd_data_s = ctrl_rd_s;
      REG_LOAD:  rd_data_s = load_r;
      REG_COUNT: rd_data_s = count_r;
      REG_STAT:  rd_data_s = stat_rd_s;
      default:   rd_data_s = 32'd0;
    endcase
  end

  // Bus handshake: one wait state, single-cycle ack, read data only while acking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      dat_r   <= 32'd0;
    end else if (req_s) begin
      state_r <= ST_ACK;
      dat_r   <= rd_data_s;
    end else begin
      state_r <= ST_IDLE;
      dat_r   <= 32'd0;
    end
  end

  // Control bits; a one-shot expiry drops EN unless the bus rewrites CTRL.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en_r <= 1'b0;
      ar_r <= 1'b0;
      ie_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      en_r <= ctrl_new_s[CTRL_EN];
      ar_r <= ctrl_new_s[CTRL_AR];
      ie_r <= ctrl_new_s[CTRL_IE];
    end else if (expire_s && !ar_r) begin
      en_r <= 1'b0;
    end
  end

  // LOAD/COUNT: bus writes win over the tick; a zero count reloads only under AR.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      load_r  <= 32'd0;
      count_r <= 32'd0;
    end else if (wr_load_s) begin
      load_r  <= load_wr_s;
      count_r <= load_wr_s;
    end else if (wr_count_s) begin
      count_r <= count_wr_s;
    end else if (tick_eff_s) begin
      if (count_r != 32'd0) begin
        count_r <= count_r - 32'd1;
      end else if (ar_r) begin
        count_r <= load_r;
      end
    end
  end

  // Status: hardware set beats write-one-to-clear; prescaler reload lives in STAT[31:16].
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_r   <= 1'b0;
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      if (expire_s) begin
        irq_r <= 1'b1;
      end else if (wr_stat_s && sel_i[0] && dat_i[STAT_IRQ]) begin
        irq_r <= 1'b0;
      end
      if (wr_stat_s) begin
        presc_r <= stat_wr_s[STAT_PRESC_LSB +: PRESC_W];
      end
    end
  end

  assign ack_o = (state_r == ST_ACK);
  assign dat_o = dat_r;
  assign irq_o = irq_r & ie_r;

endmodule

// File: tb/tb_timer_wb.sv
// Scoreboard bench for timer_wb: bus tasks queue expected read data, a negedge monitor
// compares dat_o on every ack; timing and interrupt checks are directed.
module tb_timer_wb;

  localparam logic [31:0] BASE  = 32'h00000410;
  localparam logic [31:0] A_CTRL  = 32'h00000410;
  localparam logic [31:0] A_LOAD  = 32'h00000414;
  localparam logic [31:0] A_COUNT = 32'h00000418;
  localparam logic [31:0] A_STAT  = 32'h0000041C;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] dat_o;
  logic [31:0] adr_i = 32'd0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'd0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        ack_o;
  logic        irq_o;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  int  last_commit = 0;

  timer_wb #(.base_addr(BASE), .PRESC_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .adr_i (adr_i),
    .we_i  (we_i),
    .sel_i (sel_i),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .ack_o (ack_o),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (ack_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, dat_o=0x%08h", dat_o);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk) begin
          checks++;
          if (dat_o !== e.exp) begin
            failures++;
            $display("FAIL %s: dat_o got 0x%08h expected 0x%08h", e.name, dat_o, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; the access commits on the next posedge.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic c, input logic [31:0] exp,
                     input string name);
    sb_t e;
    int  n;
    e.chk = c;
    e.exp = exp;
    e.name = name;
    sb_q.push_back(e);
    we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; cyc_i = 1'b1; stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_o && n < 8);
    if (!ack_o) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no ack after %0d cycles", name, n);
      e = sb_q.pop_back();
    end else begin
      last_commit = edge_cnt;
    end
    @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus(1'b1, adr, dat, sel, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    bus(1'b0, adr, 32'd0, 4'hF, 1'b1, exp, name);
  endtask

  task automatic at_edge(input int t, input string name);
    if (edge_cnt > t) begin
      checks++;
      failures++;
      $display("FAIL %s_sched: edge %0d already past %0d", name, edge_cnt, t);
    end
    while (edge_cnt < t) @(negedge clk);
  endtask

  initial begin
    int c;
    int acks;
    // 1: reset while a cycle is in flight
    #23 rst_i = 1'b1;
    sync();
    wr(A_LOAD, 32'h12345678, 4'hF);
    wr(A_CTRL, 32'h00000002, 4'hF);
    wr(A_STAT, 32'h00030000, 4'hF);
    adr_i = A_COUNT; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
    #2 rst_i = 1'b0;
    @(negedge clk);
    chk("t1_ack_in_reset", {31'd0, ack_o}, 32'd0);
    chk("t1_dat_in_reset", dat_o, 32'd0);
    @(negedge clk);
    chk("t1_ack_held_reset", {31'd0, ack_o}, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    rst_i = 1'b1;
    sync();
    rd(A_CTRL, 32'd0, "t1_ctrl");
    rd(A_LOAD, 32'd0, "t1_load");
    rd(A_COUNT, 32'd0, "t1_count");
    rd(A_STAT, 32'd0, "t1_stat");

    // 2: ack timing, stb held through ack, unmapped address
    sb_q.push_back('{chk: 1'b1, exp: 32'd0, name: "t2_rd_ctrl"});
    adr_i = A_CTRL; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    @(negedge clk);
    chk("t2_ack_wait_state", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    chk("t2_ack_high", {31'd0, ack_o}, 32'd1);
    @(negedge clk);
    chk("t2_ack_not_back_to_back", {31'd0, ack_o}, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    sync();
    adr_i = 32'h00000420; cyc_i = 1'b1; stb_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    chk("t2_no_hit_no_ack", acks, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    sync();

    // 3: one-shot, PRESC=0, LOAD=3
    wr(A_STAT, 32'h00000000, 4'hF);
    wr(A_LOAD, 32'd3, 4'hF);
    wr(A_CTRL, 32'h00000005, 4'hF);
    c = last_commit;
    at_edge(c + 2, "t3");
    chk("t3_irq_before", {31'd0, irq_o}, 32'd0);
    at_edge(c + 3, "t3");
    chk("t3_irq_expiry", {31'd0, irq_o}, 32'd1);
    sync();
    rd(A_CTRL, 32'h00000004, "t3_en_cleared");
    rd(A_COUNT, 32'd0, "t3_count_zero");
    rd(A_STAT, 32'h00000001, "t3_stat_irq");
    wr(A_STAT, 32'h00000001, 4'h1);
    @(negedge clk);
    chk("t3_irq_cleared", {31'd0, irq_o}, 32'd0);
    sync();
    rd(A_STAT, 32'd0, "t3_stat_cleared");

    // 4: auto-reload, PRESC=1, LOAD=4 -> period 10
    wr(A_STAT, 32'h00010001, 4'hF);
    wr(A_LOAD, 32'd4, 4'hF);
    wr(A_CTRL, 32'h00000007, 4'hF);
    c = last_commit;
    at_edge(c + 7, "t4");
    chk("t4_irq_pre1", {31'd0, irq_o}, 32'd0);
    at_edge(c + 8, "t4");
    chk("t4_irq_exp1", {31'd0, irq_o}, 32'd1);
    sync();
    wr(A_STAT, 32'h00000001, 4'h1);
    at_edge(c + 17, "t4");
    chk("t4_irq_pre2", {31'd0, irq_o}, 32'd0);
    at_edge(c + 18, "t4");
    chk("t4_irq_exp2", {31'd0, irq_o}, 32'd1);
    sync();
    wr(A_STAT, 32'h00000001, 4'h1);
    at_edge(c + 27, "t4");
    chk("t4_irq_pre3", {31'd0, irq_o}, 32'd0);
    at_edge(c + 28, "t4");
    chk("t4_irq_exp3", {31'd0, irq_o}, 32'd1);
    sync();
    wr(A_CTRL, 32'h00000000, 4'hF);
    wr(A_STAT, 32'h00000001, 4'hF);
    rd(A_STAT, 32'd0, "t4_stat_after");

    // 5: byte lanes on LOAD
    wr(A_LOAD, 32'h00000000, 4'hF);
    wr(A_LOAD, 32'hAABBCCDD, 4'b0101);
    rd(A_LOAD, 32'h00BB00DD, "t5_load_lanes");
    rd(A_COUNT, 32'h00BB00DD, "t5_count_lanes");

    // 6a: W1C on the expiry edge keeps IRQ set
    wr(A_LOAD, 32'd2, 4'hF);
    wr(A_CTRL, 32'h00000005, 4'hF);
    wr(A_STAT, 32'h00000001, 4'h1);
    @(negedge clk);
    chk("t6_irq_beats_w1c", {31'd0, irq_o}, 32'd1);
    sync();
    rd(A_STAT, 32'h00000001, "t6_stat_irq");
    wr(A_STAT, 32'h00000001, 4'hF);

    // 6b: COUNT write on a tick edge wins; CTRL write clearing EN eats that tick
    wr(A_LOAD, 32'd100, 4'hF);
    wr(A_CTRL, 32'h00000001, 4'hF);
    wr(A_COUNT, 32'h00000050, 4'hF);
    rd(A_COUNT, 32'h0000004F, "t6_count_write_wins");
    wr(A_CTRL, 32'h00000000, 4'hF);
    rd(A_COUNT, 32'h0000004D, "t6_en_clear_no_tick");
    rd(A_CTRL, 32'h00000000, "t6_ctrl_off");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
